// File: rtl/bayer_demosaic_2x2.sv
// Streaming 2x2 nearest-neighbour Bayer demosaic: 8-bit raw samples in raster order
// become RGB444 pixels with their linear buffer address, two clocks after each input.
module bayer_demosaic_2x2 #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int PATTERN = 0
) (
    input  logic                              clk,
    input  logic                              reset_,
    input  logic                              i_dv,
    input  logic                              i_sof,
    input  logic [7:0]                        i_pixel,
    output logic                              o_dv,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   o_addr,
    output logic [11:0]                       o_rgb,
    output logic                              o_eof
);

    localparam int X_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int Y_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int ADDR_W = $clog2(WIDTH*HEIGHT);

    localparam logic [X_W-1:0]    X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST = Y_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(WIDTH*HEIGHT - 1);

    // Every pattern is BGGR with the x and/or y parity inverted.
    localparam logic FLIP_X = (PATTERN % 2) != 0;
    localparam logic FLIP_Y = ((PATTERN / 2) % 2) != 0;

    function automatic logic [3:0] top_nibble(input logic [7:0] s);
        return s[7:4];
    endfunction

    function automatic logic [3:0] g_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8:5];
    endfunction

    logic [X_W-1:0]    x_cnt, x_cur;
    logic [Y_W-1:0]    y_cnt, y_cur;
    logic [ADDR_W-1:0] a_cnt, a_cur;

    logic [7:0] line_buf [WIDTH];

    logic              vld_p0;
    logic              x_odd_p0, y_odd_p0, border_p0, eof_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [7:0]        pix_p0, top_p0, left_p0, topleft_p0;

    logic              ex, ey;
    logic [7:0]        r_s, b_s, g1_s, g2_s;
    logic [11:0]       rgb_p0;

    // A qualified start-of-frame relabels the current sample as (0,0).
    always_comb begin
        x_cur = i_sof ? '0 : x_cnt;
        y_cur = i_sof ? '0 : y_cnt;
        a_cur = i_sof ? '0 : a_cnt;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            x_cnt <= '0;
            y_cnt <= '0;
            a_cnt <= '0;
        end else if (i_dv) begin
            x_cnt <= (x_cur == X_LAST) ? '0 : x_cur + X_W'(1);
            if (x_cur == X_LAST)
                y_cnt <= (y_cur == Y_LAST) ? '0 : y_cur + Y_W'(1);
            else
                y_cnt <= y_cur;
            a_cnt <= (a_cur == A_LAST) ? '0 : a_cur + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_dv)
            line_buf[x_cur] <= i_pixel;
    end

    // Stage p0: capture the 2x2 window; column registers shift only on accepted samples.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            vld_p0     <= 1'b0;
            x_odd_p0   <= 1'b0;
            y_odd_p0   <= 1'b0;
            border_p0  <= 1'b0;
            eof_p0     <= 1'b0;
            addr_p0    <= '0;
            pix_p0     <= '0;
            top_p0     <= '0;
            left_p0    <= '0;
            topleft_p0 <= '0;
        end else begin
            vld_p0 <= i_dv;
            if (i_dv) begin
                pix_p0     <= i_pixel;
                top_p0     <= line_buf[x_cur];
                left_p0    <= pix_p0;
                topleft_p0 <= top_p0;
                x_odd_p0   <= x_cur[0];
                y_odd_p0   <= y_cur[0];
                border_p0  <= (x_cur == '0) || (y_cur == '0);
                eof_p0     <= (x_cur == X_LAST) && (y_cur == Y_LAST);
                addr_p0    <= a_cur;
            end
        end
    end

    // Locate R, B and the two G sites in the window by the BGGR-normalised parity of (x,y).
    always_comb begin
        ex   = x_odd_p0 ^ FLIP_X;
        ey   = y_odd_p0 ^ FLIP_Y;
        r_s  = pix_p0;
        b_s  = topleft_p0;
        g1_s = left_p0;
        g2_s = top_p0;
        case ({ey, ex})
            2'b00: begin
                r_s  = topleft_p0;
                b_s  = pix_p0;
                g1_s = left_p0;
                g2_s = top_p0;
            end
            2'b01: begin
                r_s  = top_p0;
                b_s  = left_p0;
                g1_s = pix_p0;
                g2_s = topleft_p0;
            end
            2'b10: begin
                r_s  = left_p0;
                b_s  = top_p0;
                g1_s = pix_p0;
                g2_s = topleft_p0;
            end
            default: ;
        endcase
        rgb_p0 = border_p0 ? 12'h000 : {top_nibble(r_s), g_avg(g1_s, g2_s), top_nibble(b_s)};
    end

    // Stage p1: output registers hold their value between valid pixels.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            o_dv   <= 1'b0;
            o_eof  <= 1'b0;
            o_addr <= '0;
            o_rgb  <= '0;
        end else begin
            o_dv  <= vld_p0;
            o_eof <= vld_p0 && eof_p0;
            if (vld_p0) begin
                o_addr <= addr_p0;
                o_rgb  <= rgb_p0;
            end
        end
    end

endmodule

// File: tb/tb_bayer_demosaic_2x2.sv
// Scoreboard bench for bayer_demosaic_2x2: one BGGR and one RGGB instance share a
// small-frame stimulus stream; a negedge monitor pops expected pixels as they appear.
module tb_bayer_demosaic_2x2;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = $clog2(W*H);

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          i_dv = 1'b0;
    logic          i_sof = 1'b0;
    logic [7:0]    i_pixel = 8'h00;
    logic          o_dv0, o_eof0, o_dv3, o_eof3;
    logic [AW-1:0] o_addr0, o_addr3;
    logic [11:0]   o_rgb0, o_rgb3;

    always #5 clk = ~clk;

    bayer_demosaic_2x2 #(.WIDTH(W), .HEIGHT(H), .PATTERN(0)) u_dut0 (
        .clk(clk), .reset_(reset_), .i_dv(i_dv), .i_sof(i_sof), .i_pixel(i_pixel),
        .o_dv(o_dv0), .o_addr(o_addr0), .o_rgb(o_rgb0), .o_eof(o_eof0)
    );

    bayer_demosaic_2x2 #(.WIDTH(W), .HEIGHT(H), .PATTERN(3)) u_dut3 (
        .clk(clk), .reset_(reset_), .i_dv(i_dv), .i_sof(i_sof), .i_pixel(i_pixel),
        .o_dv(o_dv3), .o_addr(o_addr3), .o_rgb(o_rgb3), .o_eof(o_eof3)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   rgb;
        logic          eof;
        int            cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   mx = 0;
    int   my = 0;
    int   vec = 0;

    // Physical site values per vector (B at even/even, G on even row, G on odd row, R)
    // and the hand-computed interior pixel for the BGGR and RGGB instances.
    logic [7:0]  vb  [5] = '{8'hF0, 8'h30, 8'hFF, 8'h0F, 8'h12};
    logic [7:0]  vge [5] = '{8'h80, 8'hF0, 8'hFF, 8'h08, 8'h9F};
    logic [7:0]  vgo [5] = '{8'h80, 8'h10, 8'hFF, 8'h10, 8'h80};
    logic [7:0]  vr  [5] = '{8'h10, 8'hC7, 8'hFF, 8'h5A, 8'hE4};
    logic [11:0] ve0 [5] = '{12'h18F, 12'hC83, 12'hFFF, 12'h500, 12'hE81};
    logic [11:0] ve3 [5] = '{12'hF81, 12'h38C, 12'hFFF, 12'h005, 12'h18E};

    logic [AW-1:0] h_addr [2];
    logic [11:0]   h_rgb  [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int d, input string name, input logic [31:0] act,
                         input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL dut%0d %s: got 0x%0h, want 0x%0h (cycle %0d)", d*3, name, act, want, cyc);
        end
    endtask

    task automatic mon(input int d, input logic dv, input logic eof,
                       input logic [AW-1:0] addr, input logic [11:0] rgb);
        exp_t e;
        int   qs;
        qs = (d == 0) ? q0.size() : q3.size();
        if (!reset_) begin
            h_addr[d] = '0;
            h_rgb[d]  = '0;
            check(d, "reset_dv", dv, 0);
            check(d, "reset_addr", addr, 0);
            check(d, "reset_rgb", rgb, 0);
        end else if (dv) begin
            if (qs == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut%0d unexpected_dv: got addr 0x%0h, want no output", d*3, addr);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q3.pop_front();
                check(d, "addr", addr, e.addr);
                check(d, "rgb", rgb, e.rgb);
                check(d, "eof", eof, e.eof);
                check(d, "latency_cycle", cyc, e.cyc);
                h_addr[d] = addr;
                h_rgb[d]  = rgb;
            end
        end else begin
            check(d, "hold_addr", addr, h_addr[d]);
            check(d, "hold_rgb", rgb, h_rgb[d]);
            check(d, "eof_idle", eof, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, o_dv0, o_eof0, o_addr0, o_rgb0);
        mon(1, o_dv3, o_eof3, o_addr3, o_rgb3);
    end

    task automatic send(input logic sof);
        exp_t       e;
        logic [7:0] px;
        @(posedge clk);
        #1;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        if (my % 2 == 0) px = (mx % 2 == 0) ? vb[vec]  : vge[vec];
        else             px = (mx % 2 == 0) ? vgo[vec] : vr[vec];
        i_dv    = 1'b1;
        i_sof   = sof;
        i_pixel = px;
        e.addr = AW'(my*W + mx);
        e.eof  = (mx == W-1) && (my == H-1);
        e.cyc  = cyc + 2;
        e.rgb  = (mx == 0 || my == 0) ? 12'h000 : ve0[vec];
        q0.push_back(e);
        e.rgb  = (mx == 0 || my == 0) ? 12'h000 : ve3[vec];
        q3.push_back(e);
        mx++;
        if (mx == W) begin
            mx = 0;
            my++;
            if (my == H) my = 0;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        i_dv    = 1'b0;
        i_sof   = $urandom_range(0, 1) != 0;
        i_pixel = 8'($urandom);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check(0, "por_dv", o_dv0, 0);
        check(0, "por_addr", o_addr0, 0);
        check(0, "por_rgb", o_rgb0, 0);
        check(1, "por_eof", o_eof3, 0);
        reset_ = 1'b1;
        idle();

        // Five back-to-back frames; only the first carries i_sof, the rest rely on wrap.
        for (int v = 0; v < 5; v++) begin
            vec = v;
            for (int p = 0; p < W*H; p++) send(v == 0 && p == 0);
        end

        // Two lines with i_dv every third cycle.
        vec = 0;
        for (int p = 0; p < 2*W; p++) begin
            send(p == 0);
            idle();
            idle();
        end

        // Start-of-frame arriving at x=3, y=2.
        vec = 1;
        for (int p = 0; p < 2*W + 3; p++) send(p == 0);
        send(1'b1);
        for (int p = 0; p < 10; p++) send(1'b0);

        // One-cycle reset pulse mid-line with the pipeline full.
        vec = 2;
        for (int p = 0; p < 5; p++) send(p == 0);
        #2 reset_ = 1'b0;
        #1;
        check(0, "async_rst_dv", o_dv0, 0);
        check(0, "async_rst_addr", o_addr0, 0);
        check(0, "async_rst_rgb", o_rgb0, 0);
        check(1, "async_rst_dv", o_dv3, 0);
        check(1, "async_rst_rgb", o_rgb3, 0);
        q0.delete();
        q3.delete();
        mx = 0;
        my = 0;
        @(posedge clk);
        #1;
        i_dv   = 1'b0;
        i_sof  = 1'b0;
        reset_ = 1'b1;
        for (int p = 0; p < 12; p++) send(1'b0);

        repeat (5) idle();
        check(0, "queue_drained", q0.size(), 0);
        check(1, "queue_drained", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
